// File: rtl/stream_mux_nto1_if.sv
// Handshake bundle for stream_mux_nto1: N producer streams in, one consumer stream out.
// The out_beat signal exists only when STREAM_MUX_BEAT_CNT_EN is defined.
// The slave modport is the mux itself; master is the surrounding producers/consumer.
interface stream_mux_nto1_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
);
    typedef logic [CNT_W-1:0] beat_t;

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_last;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_last;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_ready;
`ifdef STREAM_MUX_BEAT_CNT_EN
    beat_t                    out_beat;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch, out_beat
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch, out_beat
    );
`else
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch
    );
`endif
endinterface

// File: rtl/stream_mux_nto1.sv
// N-input packet-aware stream multiplexer with a registered output stage.
// A channel is chosen per packet (fixed sel or round-robin) and held until its last beat.
// Optional: define STREAM_MUX_BEAT_CNT_EN to add out_beat, the saturating beat index within a packet.
module stream_mux_nto1 #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rr_en,
    input  logic [SEL_W-1:0] sel,
    stream_mux_nto1_if.slave bus
);
    typedef enum logic {IDLE, LOCK} state_t;
    typedef logic [CNT_W-1:0] beat_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  cur_ch, cur_ch_nxt;
    logic [SEL_W-1:0]  last_grant;
    logic              grant_ok;
    logic [SEL_W-1:0]  grant_ch;
    logic [SEL_W-1:0]  rr_cand;
    logic              out_free;
    logic              in_fire;
    logic              last_fire;
    logic [DATA_W-1:0] ch_data [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_data[k] = bus.in_data[k*DATA_W +: DATA_W];
    end

    // Channel selection while IDLE: fixed select or round-robin after last_grant
    always_comb begin
        grant_ok = 1'b0;
        grant_ch = '0;
        rr_cand  = '0;
        if (rr_en) begin
            for (int unsigned i = 1; i <= NUM_CH; i++) begin
                rr_cand = SEL_W'((32'(last_grant) + i) % NUM_CH);
                if (!grant_ok && bus.in_valid[rr_cand]) begin
                    grant_ok = 1'b1;
                    grant_ch = rr_cand;
                end
            end
        end else if ((32'(sel) < NUM_CH) && bus.in_valid[sel]) begin
            grant_ok = 1'b1;
            grant_ch = sel;
        end
    end

    // Input handshake: only the locked channel may transfer, and only if the output slot frees up
    always_comb begin
        out_free     = !bus.out_valid || bus.out_ready;
        bus.in_ready = '0;
        if (state == LOCK) begin
            bus.in_ready[cur_ch] = out_free;
        end
        in_fire   = (state == LOCK) && bus.in_valid[cur_ch] && out_free;
        last_fire = in_fire && bus.in_last[cur_ch];
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cur_ch <= '0;
        end else begin
            state  <= state_nxt;
            cur_ch <= cur_ch_nxt;
        end
    end

    // FSM next state: grant opens a packet, the transferred last beat closes it
    always_comb begin
        state_nxt  = state;
        cur_ch_nxt = cur_ch;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    state_nxt  = LOCK;
                    cur_ch_nxt = grant_ch;
                end
            end
            LOCK: begin
                if (last_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Round-robin pointer; reset value makes the first search start at channel 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= SEL_W'(NUM_CH - 1);
        end else if (last_fire) begin
            last_grant <= cur_ch;
        end
    end

    // Output register: reload on input transfer, drain on output transfer, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_ch    <= '0;
        end else if (in_fire) begin
            bus.out_data  <= ch_data[cur_ch];
            bus.out_valid <= 1'b1;
            bus.out_last  <= bus.in_last[cur_ch];
            bus.out_ch    <= cur_ch;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_BEAT_CNT_EN
    beat_t beat_q;

    // Beat index of the next accepted beat; cleared on grant, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q       <= '0;
            bus.out_beat <= '0;
        end else if (state == IDLE) begin
            if (grant_ok) begin
                beat_q <= '0;
            end
        end else if (in_fire) begin
            bus.out_beat <= beat_q;
            if (beat_q != '1) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Randomised scoreboard bench for stream_mux_nto1: packet-level arbitration model, queued expectations.
module tb_stream_mux_nto1;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 2;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
        logic [SEL_W-1:0]  ch;
        logic [CNT_W-1:0]  b;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rr_en = 1'b0;
    logic [SEL_W-1:0] sel = '0;

    always #5 clk = ~clk;

    stream_mux_nto1_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    stream_mux_nto1 #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .rr_en (rr_en),
        .sel   (sel),
        .bus   (bus)
    );

    beat_t srcq [NUM_CH][$];
    exp_t  expq [$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    midpkt [NUM_CH];
    bit    fire_pend [NUM_CH];
    bit    junk [NUM_CH];
    int    hold_off [NUM_CH];
    bit    rand_drop = 0;
    bit    ordy_rand = 0;
    int    ordy_hold = 0;
    int    model_lg = NUM_CH - 1;
    int    fire_cyc [$];
    int    obs_ch [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat(input int b);
        logic [CNT_W-1:0] ones;
        ones = '1;
        return (b > int'(ones)) ? ones : CNT_W'(b);
    endfunction

    // Queue one packet of len beats on channel ch, payload base+i
    task automatic add_pkt(input int ch, input int len, input int base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = DATA_W'(base + i);
            b.l = (i == len - 1);
            srcq[ch].push_back(b);
        end
    endtask

    // Packet-level reference: order of whole packets from the arbitration rule, then beats in order
    task automatic build_expect(input bit rr, input int s);
        int   ptr [NUM_CH];
        int   ch;
        int   bi;
        bit   found;
        exp_t e;
        for (int k = 0; k < NUM_CH; k++) ptr[k] = 0;
        forever begin
            found = 0;
            ch = 0;
            if (rr) begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    if (!found && ptr[(model_lg + i) % NUM_CH] < srcq[(model_lg + i) % NUM_CH].size()) begin
                        found = 1;
                        ch = (model_lg + i) % NUM_CH;
                    end
                end
            end else if (ptr[s] < srcq[s].size()) begin
                found = 1;
                ch = s;
            end
            if (!found) break;
            bi = 0;
            forever begin
                e.d  = srcq[ch][ptr[ch]].d;
                e.l  = srcq[ch][ptr[ch]].l;
                e.ch = SEL_W'(ch);
                e.b  = sat(bi);
                expq.push_back(e);
                ptr[ch]++;
                bi++;
                if (e.l) break;
            end
            model_lg = ch;
        end
    endtask

    // One cycle of producer/consumer activity, driven on the falling edge
    task automatic step();
        logic [NUM_CH*DATA_W-1:0] dv;
        logic [NUM_CH-1:0]        vv;
        logic [NUM_CH-1:0]        lv;
        beat_t                    b;
        @(negedge clk);
        cyc++;
        dv = '0;
        vv = '0;
        lv = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (fire_pend[k]) begin
                b = srcq[k].pop_front();
                midpkt[k] = !b.l;
            end
            fire_pend[k] = 0;
            if (srcq[k].size() > 0) begin
                vv[k] = 1'b1;
                if (midpkt[k]) begin
                    if (hold_off[k] > 0) begin
                        vv[k] = 1'b0;
                        hold_off[k]--;
                    end else if (rand_drop && $urandom_range(0, 3) == 0) begin
                        vv[k] = 1'b0;
                    end
                end
                dv[k*DATA_W +: DATA_W] = srcq[k][0].d;
                lv[k] = srcq[k][0].l;
            end else if (junk[k]) begin
                vv[k] = 1'b1;
                dv[k*DATA_W +: DATA_W] = 8'hEE;
                lv[k] = 1'b1;
            end
        end
        bus.in_data  = dv;
        bus.in_valid = vv;
        bus.in_last  = lv;
        if (ordy_hold > 0) begin
            bus.out_ready = 1'b0;
            ordy_hold--;
        end else begin
            bus.out_ready = ordy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            fire_pend[k] = bus.in_valid[k] && bus.in_ready[k] && (srcq[k].size() > 0);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NUM_CH; k++) begin
            srcq[k].delete();
            midpkt[k] = 0;
            fire_pend[k] = 0;
            hold_off[k] = 0;
            junk[k] = 0;
        end
        expq.delete();
        model_lg = NUM_CH - 1;
        bus.in_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called right after a step with the mux idle; inputs are parked before the next edge
    task automatic configure(input bit rr, input int s, input bit jnk);
        bus.in_valid = '0;
        rr_en = rr;
        sel = SEL_W'(s);
        for (int k = 0; k < NUM_CH; k++) junk[k] = jnk && (k != s);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (expq.size() != 0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d beats outstanding required 0", name, expq.size());
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks handshake properties
    logic                    prev_stall = 1'b0;
    logic [DATA_W+SEL_W:0]   prev_vals = '0;
    always @(negedge clk) begin
        exp_t             e;
        logic [NUM_CH-1:0] selmask;
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_stable", 32'({bus.out_data, bus.out_last, bus.out_ch}), 32'(prev_vals));
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
            end
            if (bus.in_ready != '0) begin
                chk("ready_onehot", 32'($countones(bus.in_ready)), 32'd1);
                chk("ready_while_full", 32'(!bus.out_valid || bus.out_ready), 32'd1);
                if (!rr_en) begin
                    selmask = NUM_CH'(1) << sel;
                    chk("ready_fixed_sel", 32'(bus.in_ready), 32'(selmask));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                fire_cyc.push_back(cyc);
                obs_ch.push_back(int'(bus.out_ch));
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got data %0h ch %0d required no output", bus.out_data, bus.out_ch);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.d));
                    chk("out_last", 32'(bus.out_last), 32'(e.l));
                    chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
`ifdef STREAM_MUX_BEAT_CNT_EN
                    chk("out_beat", 32'(bus.out_beat), 32'(e.b));
`endif
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_vals  = {bus.out_data, bus.out_last, bus.out_ch};
        end
    end

    initial begin
        int seen;
        int exp_order [6];
        bus.in_data = '0;
        bus.in_valid = '0;
        bus.in_last = '0;
        bus.out_ready = 1'b0;
        clear_model();

        // Reset values (rst high from time zero, first clock edge applies it)
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef STREAM_MUX_BEAT_CNT_EN
        chk("rst_out_beat", 32'(bus.out_beat), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Fixed sel=1, 3-beat packet A1..A3, other channels valid with junk
        configure(0, 1, 1);
        add_pkt(1, 3, 'hA1);
        build_expect(0, 1);
        fire_cyc.delete();
        drain("fixed_sel1", 50);
        if (fire_cyc.size() == 3) chk("fixed_back_to_back", 32'(fire_cyc[2] - fire_cyc[0]), 32'd2);
        else chk("fixed_beat_count", 32'(fire_cyc.size()), 32'd3);

        // Out-of-range select: nothing must ever be granted
        configure(0, 3, 1);
        seen = 0;
        repeat (20) begin
            step();
            if (bus.out_valid || bus.in_ready != '0) seen++;
        end
        chk("sel_oob_no_grant", 32'(seen), 32'd0);

        // Round-robin from reset, all channels with back-to-back single-beat packets
        do_reset();
        configure(1, 0, 0);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_CH; k++) add_pkt(k, 1, 16 * k + r);
        build_expect(1, 0);
        fire_cyc.delete();
        obs_ch.delete();
        drain("rr_single", 100);
        exp_order = '{0, 1, 2, 0, 1, 2};
        chk("rr_count", 32'(obs_ch.size()), 32'd6);
        for (int i = 0; i < 6 && i < obs_ch.size(); i++) chk("rr_order", 32'(obs_ch[i]), 32'(exp_order[i]));
        for (int i = 1; i < fire_cyc.size(); i++) chk("rr_bubble", 32'(fire_cyc[i] - fire_cyc[i-1]), 32'd2);

        // Backpressure: out_ready low for 4 cycles mid-packet
        configure(0, 0, 0);
        add_pkt(0, 6, 'h30);
        build_expect(0, 0);
        repeat (3) step();
        ordy_hold = 4;
        drain("backpressure", 60);

        // Locked channel stalls mid-packet for 2 cycles while another channel waits
        do_reset();
        configure(1, 0, 0);
        add_pkt(0, 4, 'h50);
        add_pkt(2, 2, 'h70);
        hold_off[0] = 2;
        build_expect(1, 0);
        drain("lock_hold", 60);

        // Beat counter saturation (CNT_W=2): a 6-beat packet
        configure(0, 2, 1);
        add_pkt(2, 6, 'h90);
        build_expect(0, 2);
        drain("beat_sat", 60);

        // Randomised fixed-mode rounds
        ordy_rand = 1;
        rand_drop = 1;
        for (int r = 0; r < 3; r++) begin
            configure(0, $urandom_range(0, NUM_CH - 1), 1);
            for (int p = 0; p < int'($urandom_range(1, 3)); p++)
                add_pkt(int'(sel), $urandom_range(1, 6), $urandom_range(0, 255));
            build_expect(0, int'(sel));
            drain("rand_fixed", 500);
        end

        // Randomised round-robin rounds
        for (int r = 0; r < 6; r++) begin
            configure(1, 0, 0);
            for (int k = 0; k < NUM_CH; k++)
                for (int p = 0; p < int'($urandom_range(0, 3)); p++)
                    add_pkt(k, $urandom_range(1, 6), $urandom_range(0, 255));
            build_expect(1, 0);
            drain("rand_rr", 2000);
        end

        // Reset asserted mid-packet clears outputs before the next clock edge
        ordy_rand = 0;
        rand_drop = 0;
        configure(1, 0, 0);
        add_pkt(1, 5, 'hC0);
        build_expect(1, 0);
        repeat (4) step();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_data", 32'(bus.out_data), 32'd0);
        chk("async_rst_last", 32'(bus.out_last), 32'd0);
        chk("async_rst_ch", 32'(bus.out_ch), 32'd0);
        chk("async_rst_ready", 32'(bus.in_ready), 32'd0);
`ifdef STREAM_MUX_BEAT_CNT_EN
        chk("async_rst_beat", 32'(bus.out_beat), 32'd0);
`endif
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        configure(1, 0, 0);
        add_pkt(1, 3, 'hD0);
        build_expect(1, 0);
        drain("post_rst", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
